// File: rtl/tff_bank_arbiter.sv
// Round-robin arbitrated bank of T flip-flops: the winning requester's mask is toggled into q.
// Define TFF_ARB_FIXED_PRI_EN for fixed lowest-index-wins priority instead of round-robin.
module tff_bank_arbiter #(
  parameter int NREQ  = 4,
  parameter int WIDTH = 8,
  parameter int PW    = 2
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic [NREQ-1:0]         req,
  input  logic [NREQ*WIDTH-1:0]   mask,
  output logic [NREQ-1:0]         gnt,
  output logic [NREQ-1:0]         done,
  output logic [WIDTH-1:0]        q,
  output logic                    busy
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    APPLY = 2'd1,
    ACK   = 2'd2
  } state_t;

  // Reject pointer widths that cannot address exactly the requester range.
  if (NREQ < 2 || NREQ > 16 || PW != $clog2(NREQ)) begin : g_bad_param
    $error("tff_bank_arbiter: NREQ must be 2..16 and PW must equal clog2(NREQ)");
  end

  state_t           state_q;
  state_t           state_n;
  logic [PW-1:0]    ptr;
  logic [PW-1:0]    widx;
  logic [WIDTH-1:0] mlat;
  logic             found;
  logic [PW-1:0]    win;
  int               base;

`ifdef TFF_ARB_FIXED_PRI_EN
  assign base = 0;
`else
  assign base = int'(ptr);
`endif

  // Search starts at the pointer and wraps, so the first hit is the fairest winner.
  always_comb begin : arb
    int j;
    // NOTE: every combinational output gets a default first so no path leaves it unassigned (no latch).
    found = 1'b0;
    win   = '0;
    j     = 0;
    for (int k = 0; k < NREQ; k++) begin
      j = base + k;
      if (j >= NREQ) j = j - NREQ;
      if (!found && req[j]) begin
        found = 1'b1;
        win   = PW'(j);
      end
    end
  end

  always_comb begin
    state_n = state_q;
    case (state_q)
      IDLE:    if (found) state_n = APPLY;
      APPLY:   state_n = ACK;
      ACK:     state_n = IDLE;
      default: state_n = IDLE;
    endcase
  end

  // NOTE: all sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      ptr     <= '0;
      widx    <= '0;
      mlat    <= '0;
      gnt     <= '0;
      done    <= '0;
      q       <= '0;
      busy    <= 1'b0;
    end else begin
      state_q <= state_n;
      busy    <= (state_n != IDLE);
      case (state_q)
        IDLE: begin
          if (found) begin
            gnt  <= NREQ'(1) << win;
            widx <= win;
            mlat <= mask[win*WIDTH +: WIDTH];
          end
        end
        APPLY: begin
          // Requester may withdraw here; the latched mask still completes the operation.
          q    <= q ^ mlat;
          done <= gnt;
        end
        ACK: begin
          gnt  <= '0;
          done <= '0;
`ifdef TFF_ARB_FIXED_PRI_EN
          ptr  <= '0;
`else
          if (int'(widx) == NREQ - 1) ptr <= '0;
          else                        ptr <= widx + 1'b1;
`endif
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_tff_bank_arbiter.sv
// Directed self-checking bench for tff_bank_arbiter (default round-robin build).
module tb_tff_bank_arbiter;

  localparam int NREQ  = 4;
  localparam int WIDTH = 8;

  logic                  clk = 1'b0;
  logic                  rst;
  logic [NREQ-1:0]       req;
  logic [NREQ*WIDTH-1:0] mask;
  logic [NREQ-1:0]       gnt;
  logic [NREQ-1:0]       done;
  logic [WIDTH-1:0]      q;
  logic                  busy;

  int n_assert = 0;
  int n_fail   = 0;

  tff_bank_arbiter #(.NREQ(NREQ), .WIDTH(WIDTH), .PW(2)) dut (
    .clk  (clk),
    .rst  (rst),
    .req  (req),
    .mask (mask),
    .gnt  (gnt),
    .done (done),
    .q    (q),
    .busy (busy)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: observed no finish, expected finish before time limit");
    $fatal(1, "watchdog expired");
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_mask(input int i, input logic [WIDTH-1:0] m);
    mask[i*WIDTH +: WIDTH] = m;
  endtask

  // Requests are already raised; follows one 3-cycle operation for winner w and drops req[w] in its done cycle.
  task automatic serve(input string tag, input int w, input logic [WIDTH-1:0] q_before,
                       input logic [WIDTH-1:0] q_after);
    logic [NREQ-1:0] oh;
    oh = NREQ'(1) << w;
    tick();
    check({tag, " gnt"},       32'(gnt),  32'(oh));
    check({tag, " busy"},      32'(busy), 32'd1);
    check({tag, " q pre"},     32'(q),    32'(q_before));
    check({tag, " no done"},   32'(done), 32'd0);
    tick();
    check({tag, " q post"},    32'(q),    32'(q_after));
    check({tag, " done"},      32'(done), 32'(oh));
    check({tag, " gnt held"},  32'(gnt),  32'(oh));
    req[w] = 1'b0;
    tick();
    check({tag, " gnt clr"},   32'(gnt),  32'd0);
    check({tag, " done clr"},  32'(done), 32'd0);
    check({tag, " idle"},      32'(busy), 32'd0);
  endtask

  initial begin
    rst  = 1'b1;
    req  = '0;
    mask = '0;
    tick();
    tick();
    check("reset q",    32'(q),    32'd0);
    check("reset gnt",  32'(gnt),  32'd0);
    check("reset done", 32'(done), 32'd0);
    check("reset busy", 32'(busy), 32'd0);
    rst = 1'b0;
    tick();
    check("idle no req gnt", 32'(gnt), 32'd0);

    // Single requester, toggle back, then zero mask; ptr ends at 2.
    set_mask(1, 8'hA5); req[1] = 1'b1;
    serve("single r1", 1, 8'h00, 8'hA5);
    req[1] = 1'b1;
    serve("toggle back", 1, 8'hA5, 8'h00);
    set_mask(1, 8'h00); req[1] = 1'b1;
    serve("zero mask", 1, 8'h00, 8'h00);

    // Withdraw and late mask change during APPLY: latched 3C still applied; ptr ends at 3.
    set_mask(2, 8'h3C); req[2] = 1'b1;
    tick();
    check("withdraw gnt", 32'(gnt), 32'b0100);
    req[2] = 1'b0;
    set_mask(2, 8'hFF);
    tick();
    check("withdraw q",    32'(q),    32'h3C);
    check("withdraw done", 32'(done), 32'b0100);
    tick();
    check("withdraw idle", 32'(busy), 32'd0);

    // Reset during APPLY of requester 3: operation discarded, ptr back to 0.
    set_mask(3, 8'hFF); req[3] = 1'b1;
    tick();
    check("abort gnt", 32'(gnt), 32'b1000);
    rst = 1'b1;
    req = '0;
    tick();
    check("abort q",    32'(q),    32'd0);
    check("abort gnt0", 32'(gnt),  32'd0);
    check("abort done", 32'(done), 32'd0);
    check("abort busy", 32'(busy), 32'd0);
    rst = 1'b0;
    tick();
    check("abort no done 1", 32'(done), 32'd0);
    tick();
    check("abort no done 2", 32'(done), 32'd0);
    check("abort q stays",   32'(q),    32'd0);

    // Round-robin contention from ptr=0: order 0,1,2,3, three cycles apart.
    set_mask(0, 8'h01); set_mask(1, 8'h02); set_mask(2, 8'h04); set_mask(3, 8'h08);
    req = 4'b1111;
    serve("rr 0", 0, 8'h00, 8'h01);
    serve("rr 1", 1, 8'h01, 8'h03);
    serve("rr 2", 2, 8'h03, 8'h07);
    serve("rr 3", 3, 8'h07, 8'h0F);

    // ptr wrapped to 0: 1010 grants 1 then 3.
    req = 4'b1010;
    serve("wrap a1", 1, 8'h0F, 8'h0D);
    serve("wrap a3", 3, 8'h0D, 8'h05);

    // Serve 2 (ptr -> 3), then 0011 wraps to 0 before 1.
    req[2] = 1'b1;
    serve("wrap b2", 2, 8'h05, 8'h01);
    req = 4'b0011;
    serve("wrap b0", 0, 8'h01, 8'h00);
    serve("wrap b1", 1, 8'h00, 8'h02);

    tick();
    check("final idle gnt", 32'(gnt), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule

// File: doc/tff_bank_arbiter.md
Name: tff_bank_arbiter

Overview:
- Shares one WIDTH-bit bank of T flip-flops among NREQ requesters.
- Each requester asks for a toggle operation by asserting req with a toggle mask.
- A round-robin arbiter grants one requester at a time.
- A small FSM applies q <= q ^ mask for the winner and returns a one-cycle done pulse.
- Sits between control agents and the shared toggle-state register; the bank is the only writer of q.

Parameters:
- NREQ, 4, number of requesters (2..16).
- WIDTH, 8, width of the toggle bank.
- PW, 2, pointer width = ceil(log2(NREQ)); must be consistent with NREQ.

Ports:
- clk    input   1           clock, rising edge.
- rst    input   1           reset, synchronous, active-high.
- req    input   NREQ        per-requester request; held high until that requester's done.
- mask   input   NREQ*WIDTH  per-requester toggle mask; slice i = mask[i*WIDTH +: WIDTH]; held stable while req[i] is high.
- gnt    output  NREQ        one-hot grant; all zero when idle.
- done   output  NREQ        one-hot, one-cycle completion pulse.
- q      output  WIDTH       shared bank state.
- busy   output  1           high whenever the FSM is not in IDLE.

Behaviour:
- Reset: rst is sampled on a rising clk edge, synchronous, active-high.
  - q=0, gnt=0, done=0, busy=0, state=IDLE, round-robin pointer ptr=0, latched mask=0.
  - Reset overrides any operation in progress; a partially completed operation is discarded and q is cleared.
- FSM states: IDLE, APPLY, ACK.
  - IDLE: if req==0, stay.
    - Otherwise pick winner w = first i with req[i]=1, searching ptr, ptr+1, ... with wrap modulo NREQ.
    - Register gnt = onehot(w) and mlat = mask slice w; go to APPLY.
  - APPLY: q <= q ^ mlat; gnt held; go to ACK.
    - req[w] is ignored in this state; withdrawing it does not abort the operation.
  - ACK: done = onehot(w) and gnt held for this cycle.
    - On exit: gnt <= 0, done <= 0, ptr <= (w+1) mod NREQ; go to IDLE.
- Timing: req[i] high before edge E (FSM in IDLE) gives:
  - gnt valid after E;
  - q updated after E+1;
  - done pulse in the cycle after E+1;
  - gnt/done low after E+2;
  - next arbitration at edge E+3.
- Throughput: one operation per 3 cycles under continuous contention.
- Requester obligation: drop req within the done cycle. If req is still high at the next IDLE sample, it is treated as a new request.
- Fairness: a requester with req held continuously is granted within NREQ operations.
- Zero mask: the operation completes normally with full handshake; q is unchanged.
- Mask changes after grant have no effect because the mask is latched at grant.
- Requests arriving during APPLY/ACK wait for IDLE. No request is lost while it is held.
- ptr wraps from NREQ-1 to 0.
- Outputs are registered; there is no combinational path from req/mask to any output.

Optional Feature:
- Macro: TFF_ARB_FIXED_PRI_EN.
- Defined: fixed priority; lowest index wins, ptr is unused and held at 0. Starvation of high indices is permitted.
- Undefined (default): round-robin as specified above.
- Handshake and timing are identical in both modes.

Test Plan:
- Reset, single requester:
  - rst for 2 cycles -> q=0, gnt=0, busy=0.
  - req[1]=1, mask1=8'hA5 -> gnt=4'b0010 next cycle; q=8'hA5 one cycle later; done=4'b0010 for exactly one cycle; idle after.
- Toggle-back: repeat the req[1] operation with mask 8'hA5 -> q returns to 8'h00. Then mask 8'h00 -> done pulses, q stays 8'h00.
- Round-robin contention:
  - req=4'b1111, masks 01/02/04/08, each requester drops req on its done.
  - Grant order 0,1,2,3; final q=8'h0F; operations 3 cycles apart.
  - With TFF_ARB_FIXED_PRI_EN defined and req re-asserted immediately after done, requester 0 wins every time.
- Wrap-around:
  - After requester 3 is served (ptr=0), assert req=4'b1010 -> grant 1 first, then 3.
  - After serving 2, assert req=4'b0011 -> grant 0 (wrap), then 1.
- Withdraw and late mask:
  - req[2] granted, then req[2] dropped and mask2 changed during APPLY -> the originally latched mask is applied and done[2] still pulses.
- Reset mid-operation:
  - q=8'h3C, grant active in APPLY, assert rst -> next cycle q=0, gnt=0, done=0, busy=0, ptr=0.
  - No done pulse is emitted for the aborted operation.
